execution_muldiv: RTL and testbench
===================================

Name: execution_muldiv

Overview:
Parametrised successor to the single-cycle MIPS execution stage. It sits between the ID/EX and EX/MEM pipeline registers and registers ALU result, store data, MEM/WB control and PC for the memory stage. It adds an iterative signed/unsigned multiply/divide unit with HI/LO registers, MFHI/MFLO, and a stall output toward hazard control.

Parameters:
NB_REG, 32, datapath width (even, >= 8)
NB_INM, 16, immediate width (<= NB_REG)
NB_EX, 7, EX control width: {alu_ctrl[4:0], b_sel, s_u}
NB_MEM, 5, MEM control width (pass-through)
NB_WB, 8, WB control width (pass-through)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-low
i_valid  in  1  stage enable; low holds all state
i_a  in  NB_REG  operand A (rs)
i_b  in  NB_REG  operand B (rt)
i_inm  in  NB_INM  immediate
i_ex  in  NB_EX  EX control
i_mem  in  NB_MEM  MEM control
i_wb  in  NB_WB  WB control
i_pc  in  NB_REG  PC+4
o_alu  out  NB_REG  registered result
o_b  out  NB_REG  registered i_b (store data)
o_mem  out  NB_MEM  registered MEM control
o_wb  out  NB_WB  registered WB control
o_pc  out  NB_REG  registered PC
o_stall  out  1  combinational stall request
o_busy  out  1  mul/div unit active

Behaviour:
- Reset (i_reset=0, async): all outputs 0, HI=LO=0, FSM IDLE, counter 0; in-flight mul/div aborted.
- Operand B: b_sel=1 selects immediate, zero-extended if s_u=1 else sign-extended; b_sel=0 selects i_b.
- alu_ctrl: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 NOR, 00110 SRL, 00111 SLL, 01000 SRA, 01001 SLA(=SLL), 01010 SLT (SLTU if s_u=1), 01011 LUI ({inm, zeros}), 01100 MULT, 01101 DIV, 01110 MFHI, 01111 MFLO; others give 0. Shifts: B shifted by A[clog2(NB_REG)-1:0]. ADD/SUB wrap modulo 2^NB_REG, no overflow trap.
- Latency: ALU ops 1 cycle; outputs update on rising edge when i_valid=1 and o_stall=0. i_valid=0: all registers hold.
- o_stall = i_valid & o_busy & (op in MULT,DIV,MFHI,MFLO). Stall edge inserts bubble: o_mem=0, o_wb=0, o_alu/o_b/o_pc hold. Upstream holds inputs.
- Other ops proceed while o_busy=1 (no stall).
- FSM: IDLE -(accepted MULT/DIV)-> BUSY -(counter==0)-> FIX -> IDLE. Accept latches |A|,|B| (raw if s_u=1) and result signs, loads counter NB_REG-1. BUSY: one shift-add (MULT) or restoring-subtract (DIV) bit per cycle, NB_REG cycles. FIX: applies signs, writes HI/LO. o_busy=1 in BUSY and FIX: NB_REG+1 cycles after the accept edge. MULT/DIV writes o_wb=0, o_mem=0.
- MULT: {HI,LO} = full 2*NB_REG product. DIV: LO=quotient truncated toward zero, HI=remainder with dividend's sign.
- Divide by zero: no trap; LO=all ones (unsigned) or sign-corrected equivalent, HI=dividend.
- MFHI/MFLO accepted the first cycle o_busy=0; they see the new HI/LO.
- i_valid=0 during BUSY: unit keeps iterating; only the pipeline registers freeze.

Optional Feature:
EXEC_MULDIV_EN: defined -> mul/div unit, HI/LO and FSM as above. Undefined -> no unit or FSM; MULT/DIV/MFHI/MFLO yield o_alu=0 with controls passed through; o_stall and o_busy tied 0.

Test Plan:
- Reset pulse mid-DIV (8 cycles in) -> o_busy=0, all outputs 0, a following MFLO returns 0.
- ADD A=1,B=1 -> o_alu=2 next edge; LUI inm=0x0002, b_sel=1, s_u=1 -> 0x00020000; SLT A=3,B=2 -> 0; NOR A=B=6 -> 0xFFFFFFF9.
- MULT signed A=0xFFFFFFFD, B=7, then MFHI/MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE.
- DIV signed A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- MFLO presented on the cycle after MULT accept -> o_stall=1 for 33 cycles, o_wb=o_mem=0 bubbles, then correct LO. An ADD in the same window completes with no stall.
- i_valid=0 for 3 cycles mid-MULT -> outputs frozen, o_busy falls 33 cycles after accept, product correct.

Source files
------------

// File: rtl/execution_muldiv.sv
// execution_muldiv: MIPS EX stage with EX/MEM registers and an iterative mul/div unit with HI/LO.
// The mul/div unit, HI/LO and its FSM exist only when EXEC_MULDIV_EN is defined.
module execution_muldiv #(
    parameter int NB_REG = 32,
    parameter int NB_INM = 16,
    parameter int NB_EX  = 7,
    parameter int NB_MEM = 5,
    parameter int NB_WB  = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_REG-1:0] i_a,
    input  logic [NB_REG-1:0] i_b,
    input  logic [NB_INM-1:0] i_inm,
    input  logic [NB_EX-1:0]  i_ex,
    input  logic [NB_MEM-1:0] i_mem,
    input  logic [NB_WB-1:0]  i_wb,
    input  logic [NB_REG-1:0] i_pc,
    output logic [NB_REG-1:0] o_alu,
    output logic [NB_REG-1:0] o_b,
    output logic [NB_MEM-1:0] o_mem,
    output logic [NB_WB-1:0]  o_wb,
    output logic [NB_REG-1:0] o_pc,
    output logic              o_stall,
    output logic              o_busy
);
    localparam int NB_SH = $clog2(NB_REG);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SRL = 5'd6, OP_SLL = 5'd7;
    localparam logic [4:0] OP_SRA = 5'd8, OP_SLA = 5'd9, OP_SLT = 5'd10, OP_LUI = 5'd11;
    localparam logic [4:0] OP_MFHI = 5'd14, OP_MFLO = 5'd15;

    logic [4:0]        w_op;
    logic              w_su;
    logic [NB_REG-1:0] w_opb;
    logic [NB_SH-1:0]  w_sh;
    logic [NB_REG-1:0] w_res;
    logic [NB_REG-1:0] w_hi;
    logic [NB_REG-1:0] w_lo;
    logic              w_kill;

    assign w_op  = i_ex[NB_EX-1 -: 5];
    assign w_su  = i_ex[0];
    assign w_sh  = i_a[NB_SH-1:0];
    assign w_opb = i_ex[1] ? (w_su ? NB_REG'(i_inm) : NB_REG'($signed(i_inm))) : i_b;

    always_comb begin
        w_res = '0;
        case (w_op)
            OP_ADD:         w_res = i_a + w_opb;
            OP_SUB:         w_res = i_a - w_opb;
            OP_AND:         w_res = i_a & w_opb;
            OP_OR:          w_res = i_a | w_opb;
            OP_XOR:         w_res = i_a ^ w_opb;
            OP_NOR:         w_res = ~(i_a | w_opb);
            OP_SRL:         w_res = w_opb >> w_sh;
            OP_SLL, OP_SLA: w_res = w_opb << w_sh;
            OP_SRA:         w_res = $signed(w_opb) >>> w_sh;
            OP_SLT:         w_res = NB_REG'(w_su ? (i_a < w_opb) : ($signed(i_a) < $signed(w_opb)));
            OP_LUI:         w_res = NB_REG'(i_inm) << (NB_REG - NB_INM);
            OP_MFHI:        w_res = w_hi;
            OP_MFLO:        w_res = w_lo;
            default:        w_res = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    localparam logic [4:0] OP_MULT = 5'd12, OP_DIV = 5'd13;
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2;

    logic [1:0]          r_state;
    logic [NB_SH-1:0]    r_cnt;
    logic [NB_REG-1:0]   r_hi, r_lo, r_opb;
    logic                r_div, r_neg_q, r_neg_r;
    logic                w_mul_div, w_md_op, w_accept, w_neg_a, w_neg_b, w_ge;
    logic [NB_REG-1:0]   w_abs_a, w_abs_b, w_sub;
    logic [NB_REG:0]     w_add, w_shl;
    logic [2*NB_REG-1:0] w_prod;

    assign w_mul_div = (w_op == OP_MULT) | (w_op == OP_DIV);
    assign w_md_op   = w_mul_div | (w_op == OP_MFHI) | (w_op == OP_MFLO);
    assign o_busy    = r_state != S_IDLE;
    assign o_stall   = i_valid & o_busy & w_md_op;
    assign w_accept  = i_valid & w_mul_div & (r_state == S_IDLE);
    assign w_neg_a   = ~w_su & i_a[NB_REG-1];
    assign w_neg_b   = ~w_su & w_opb[NB_REG-1];
    assign w_abs_a   = w_neg_a ? -i_a : i_a;
    assign w_abs_b   = w_neg_b ? -w_opb : w_opb;
    // HI/LO double as the working accumulator; MFHI/MFLO stall until FIX so partials never escape
    assign w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shl     = {r_hi, r_lo[NB_REG-1]};
    assign w_ge      = w_shl >= {1'b0, r_opb};
    assign w_sub     = w_shl[NB_REG-1:0] - r_opb;
    assign w_prod    = {r_hi, r_lo};
    assign w_hi      = r_hi;
    assign w_lo      = r_lo;
    assign w_kill    = w_mul_div;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state <= S_BUSY;
                    r_cnt   <= NB_SH'(NB_REG - 1);
                    r_hi    <= '0;
                    r_lo    <= w_abs_a;
                    r_opb   <= w_abs_b;
                    r_div   <= w_op == OP_DIV;
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                end
                S_BUSY: begin
                    r_hi  <= r_div ? (w_ge ? w_sub : w_shl[NB_REG-1:0]) : w_add[NB_REG:1];
                    r_lo  <= r_div ? {r_lo[NB_REG-2:0], w_ge} : {w_add[0], r_lo[NB_REG-1:1]};
                    r_cnt <= r_cnt - NB_SH'(1);
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (r_div) begin
                        r_lo <= r_neg_q ? -r_lo : r_lo;
                        r_hi <= r_neg_r ? -r_hi : r_hi;
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? -w_prod : w_prod;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign o_busy  = 1'b0;
    assign o_stall = 1'b0;
    assign w_hi    = '0;
    assign w_lo    = '0;
    assign w_kill  = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_alu <= '0;
            o_b   <= '0;
            o_mem <= '0;
            o_wb  <= '0;
            o_pc  <= '0;
        end else if (i_valid) begin
            if (o_stall) begin
                o_mem <= '0;
                o_wb  <= '0;
            end else begin
                o_alu <= w_res;
                o_b   <= i_b;
                o_pc  <= i_pc;
                o_mem <= w_kill ? '0 : i_mem;
                o_wb  <= w_kill ? '0 : i_wb;
            end
        end
    end
endmodule

// File: tb/tb_execution_muldiv.sv
// tb_execution_muldiv: scoreboard bench for execution_muldiv; expectations follow EXEC_MULDIV_EN.
module tb_execution_muldiv;
`ifdef EXEC_MULDIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    localparam logic [4:0] ADD = 0, SUB = 1, NOR = 5, SRA = 8, SLT = 10, LUI = 11;
    localparam logic [4:0] MULT = 12, DIV = 13, MFHI = 14, MFLO = 15;

    logic        clk = 0, rst_n = 0, valid = 0;
    logic [31:0] a = 0, b = 0, pc = 0;
    logic [15:0] inm = 0;
    logic [6:0]  ex = 0;
    logic [4:0]  mem = 0;
    logic [7:0]  wb = 0;
    logic [31:0] o_alu, o_b, o_pc;
    logic [4:0]  o_mem;
    logic [7:0]  o_wb;
    logic        o_stall, o_busy;

    typedef struct packed {
        logic [31:0] alu, b, pc;
        logic [4:0]  mem;
        logic [7:0]  wb;
    } exp_t;

    exp_t        sb[$];
    exp_t        last = '0;
    int          n_tests = 0, n_fail = 0, stalls = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    execution_muldiv dut (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_a(a), .i_b(b), .i_inm(inm),
        .i_ex(ex), .i_mem(mem), .i_wb(wb), .i_pc(pc), .o_alu(o_alu), .o_b(o_b),
        .o_mem(o_mem), .o_wb(o_wb), .o_pc(o_pc), .o_stall(o_stall), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] ia, bo,
                                              input logic [15:0] iinm, input logic su);
        case (op)
            0:       return ia + bo;
            1:       return ia - bo;
            2:       return ia & bo;
            3:       return ia | bo;
            4:       return ia ^ bo;
            5:       return ~(ia | bo);
            6:       return bo >> ia[4:0];
            7, 9:    return bo << ia[4:0];
            8:       return $signed(bo) >>> ia[4:0];
            10:      return su ? {31'b0, ia < bo} : {31'b0, $signed(ia) < $signed(bo)};
            11:      return {iinm, 16'h0};
            14:      return EN ? m_hi : 32'h0;
            15:      return EN ? m_lo : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic md_model(input logic [4:0] op, input logic [31:0] ia, bo, input logic su);
        longint          sa, sbv;
        longint unsigned p;
        sa  = longint'($signed(ia));
        sbv = longint'($signed(bo));
        if (op == MULT) begin
            p = su ? ({32'h0, ia} * {32'h0, bo}) : longint'(sa * sbv);
            {m_hi, m_lo} = p;
        end else if (bo == 0) begin
            m_lo = (!su && ia[31]) ? 32'h1 : 32'hFFFFFFFF;
            m_hi = ia;
        end else if (su) begin
            m_lo = ia / bo;
            m_hi = ia % bo;
        end else begin
            m_lo = 32'(sa / sbv);
            m_hi = 32'(sa % sbv);
        end
    endtask

    // Drives one instruction, rides out any stall checking bubbles, then scores the accepted result.
    task automatic issue(input logic [4:0] op, input logic [31:0] ia, ib, input logic [15:0] iinm,
                         input logic bsel, su, input logic [4:0] imem, input logic [7:0] iwb,
                         input logic [31:0] ipc);
        exp_t        e, g;
        logic [31:0] bo;
        a = ia; b = ib; inm = iinm; ex = {op, bsel, su}; mem = imem; wb = iwb; pc = ipc;
        valid = 1;
        bo = bsel ? (su ? {16'h0, iinm} : {{16{iinm[15]}}, iinm}) : ib;
        e = '{alu: alu_model(op, ia, bo, iinm, su), b: ib, pc: ipc, mem: imem, wb: iwb};
        if (EN && (op == MULT || op == DIV)) begin
            e.mem = 0;
            e.wb  = 0;
            md_model(op, ia, bo, su);
        end
        sb.push_back(e);
        #1;
        stalls = 0;
        while (o_stall === 1'b1 && stalls < 100) begin
            step;
            stalls++;
            n_tests++;
            if (o_mem !== 0 || o_wb !== 0 || o_alu !== last.alu || o_pc !== last.pc || o_b !== last.b) begin
                n_fail++;
                $display("FAIL bubble op=%0d: alu=%h b=%h pc=%h mem=%h wb=%h, required alu=%h b=%h pc=%h mem=0 wb=0",
                         op, o_alu, o_b, o_pc, o_mem, o_wb, last.alu, last.b, last.pc);
            end
        end
        if (stalls >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall_timeout op=%0d: stalled %0d cycles, required fewer than 100", op, stalls);
        end
        step;
        valid = 0;
        g = sb.pop_front();
        n_tests++;
        if ({o_alu, o_b, o_pc, o_mem, o_wb} !== g) begin
            n_fail++;
            $display("FAIL result op=%0d: alu=%h b=%h pc=%h mem=%h wb=%h, required alu=%h b=%h pc=%h mem=%h wb=%h",
                     op, o_alu, o_b, o_pc, o_mem, o_wb, g.alu, g.b, g.pc, g.mem, g.wb);
        end
        last = g;
    endtask

    task automatic test_reset;
        step;
        step;
        n_tests++;
        if ({o_alu, o_b, o_pc, o_mem, o_wb, o_stall, o_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset: alu=%h b=%h pc=%h mem=%h wb=%h stall=%b busy=%b, required all 0",
                     o_alu, o_b, o_pc, o_mem, o_wb, o_stall, o_busy);
        end
        rst_n = 1;
    endtask

    task automatic test_alu;
        issue(ADD, 1, 1, 0, 0, 0, 5'h03, 8'h11, 32'h100);
        n_tests++;
        if (o_alu !== 32'd2) begin n_fail++; $display("FAIL add: got %h required 00000002", o_alu); end
        issue(LUI, 0, 0, 16'h0002, 1, 1, 5'h01, 8'h22, 32'h104);
        n_tests++;
        if (o_alu !== 32'h00020000) begin n_fail++; $display("FAIL lui: got %h required 00020000", o_alu); end
        issue(SLT, 3, 2, 0, 0, 0, 0, 8'h33, 32'h108);
        n_tests++;
        if (o_alu !== 32'h0) begin n_fail++; $display("FAIL slt: got %h required 00000000", o_alu); end
        issue(NOR, 6, 6, 0, 0, 0, 5'h1F, 8'hFF, 32'h10C);
        n_tests++;
        if (o_alu !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL nor: got %h required FFFFFFF9", o_alu); end
        issue(ADD, 5, 0, 16'hFFFF, 1, 0, 0, 0, 32'h110);
        n_tests++;
        if (o_alu !== 32'h4) begin n_fail++; $display("FAIL addi_sext: got %h required 00000004", o_alu); end
        issue(ADD, 5, 0, 16'hFFFF, 1, 1, 0, 0, 32'h114);
        issue(SUB, 5, 7, 0, 0, 0, 0, 0, 32'h118);
        issue(SRA, 4, 32'h80000000, 0, 0, 0, 0, 0, 32'h11C);
        issue(SLT, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 32'h120);
        issue(SLT, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 32'h124);
        issue(5'd6, 36, 32'hF0000000, 0, 0, 0, 0, 0, 32'h128);
        issue(5'd9, 3, 32'h1, 0, 0, 0, 0, 0, 32'h12C);
        issue(5'd20, 9, 9, 0, 0, 0, 5'h02, 8'h02, 32'h130);
    endtask

    task automatic test_muldiv;
        issue(MULT, 32'hFFFFFFFD, 7, 0, 0, 0, 5'h1F, 8'hFF, 32'h200);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h204);
        n_tests++;
        if (o_alu !== (EN ? 32'hFFFFFFFF : 32'h0)) begin n_fail++; $display("FAIL mult_hi: got %h", o_alu); end
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h208);
        n_tests++;
        if (o_alu !== (EN ? 32'hFFFFFFEB : 32'h0)) begin n_fail++; $display("FAIL mult_lo: got %h", o_alu); end
        issue(MULT, 32'hFFFFFFFF, 2, 0, 0, 1, 0, 0, 32'h20C);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h210);
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h214);
        issue(DIV, -32'sd7, 2, 0, 0, 0, 0, 0, 32'h218);
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h21C);
        n_tests++;
        if (o_alu !== (EN ? 32'hFFFFFFFD : 32'h0)) begin n_fail++; $display("FAIL div_q: got %h", o_alu); end
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h220);
        issue(DIV, 5, 0, 0, 0, 1, 0, 0, 32'h224);
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h228);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h22C);
        n_tests++;
        if (o_alu !== (EN ? 32'h5 : 32'h0)) begin n_fail++; $display("FAIL divu0_hi: got %h", o_alu); end
        issue(DIV, -32'sd9, 0, 0, 0, 0, 0, 0, 32'h230);
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h234);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h238);
        issue(DIV, 100, -32'sd7, 0, 0, 0, 0, 0, 32'h23C);
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h240);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h244);
    endtask

    task automatic test_stall;
        issue(MULT, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 0, 0, 32'h300);
        issue(MFLO, 0, 0, 0, 0, 0, 5'h04, 8'h04, 32'h304);
        n_tests++;
        if (stalls !== (EN ? 33 : 0)) begin n_fail++; $display("FAIL stall_len: got %0d required %0d", stalls, EN ? 33 : 0); end
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h308);
    endtask

    task automatic test_back_to_back;
        issue(MULT, 123456, 32'hFFFFFCEB, 0, 0, 0, 0, 0, 32'h400);
        issue(ADD, 40, 2, 0, 0, 0, 5'h1F, 8'hAA, 32'h404);
        n_tests++;
        if (stalls !== 0 || o_busy !== EN) begin
            n_fail++;
            $display("FAIL overlap_add: stalls=%0d busy=%b required stalls=0 busy=%b", stalls, o_busy, EN);
        end
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h408);
        n_tests++;
        if (stalls !== (EN ? 32 : 0)) begin n_fail++; $display("FAIL overlap_stall: got %0d required %0d", stalls, EN ? 32 : 0); end
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h40C);
    endtask

    task automatic test_freeze;
        int c;
        issue(MULT, 32'hDEADBEEF, 32'h1234, 0, 0, 0, 5'h01, 8'h01, 32'h500);
        a = 32'h77; b = 32'h99; ex = 0; mem = 5'h1F; wb = 8'hFF; pc = 32'hFFF0;
        c = 0;
        repeat (3) begin
            step;
            c++;
            n_tests++;
            if ({o_alu, o_b, o_pc, o_mem, o_wb} !== last) begin
                n_fail++;
                $display("FAIL freeze: alu=%h b=%h pc=%h mem=%h wb=%h, required alu=%h b=%h pc=%h mem=%h wb=%h",
                         o_alu, o_b, o_pc, o_mem, o_wb, last.alu, last.b, last.pc, last.mem, last.wb);
            end
        end
        while (o_busy === 1'b1 && c < 100) begin
            step;
            c++;
        end
        n_tests++;
        if (c !== (EN ? 33 : 3)) begin n_fail++; $display("FAIL busy_len: got %0d required %0d", c, EN ? 33 : 3); end
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h504);
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h508);
    endtask

    task automatic test_reset_mid_div;
        issue(DIV, 1000, 7, 0, 0, 0, 0, 0, 32'h600);
        repeat (8) step;
        rst_n = 0;
        #1;
        n_tests++;
        if ({o_alu, o_b, o_pc, o_mem, o_wb, o_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_div: alu=%h b=%h pc=%h mem=%h wb=%h busy=%b, required all 0",
                     o_alu, o_b, o_pc, o_mem, o_wb, o_busy);
        end
        m_hi = 0;
        m_lo = 0;
        last = '0;
        step;
        rst_n = 1;
        issue(MFLO, 0, 0, 0, 0, 0, 0, 8'h01, 32'h604);
        n_tests++;
        if (o_alu !== 32'h0 || stalls !== 0) begin
            n_fail++;
            $display("FAIL mflo_after_reset: alu=%h stalls=%0d required alu=0 stalls=0", o_alu, stalls);
        end
        issue(MFHI, 0, 0, 0, 0, 0, 0, 8'h01, 32'h608);
    endtask

    initial begin
        test_reset;
        test_alu;
        test_muldiv;
        test_stall;
        test_back_to_back;
        test_freeze;
        test_reset_mid_div;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
